// File: rtl/stripe_pkg.sv
// stripe_pkg: shared types and constants for the byte striping / unstriping blocks
//   state_t       : striping FSM state {EMPTY, HALF}
//   STRIPE_DATA_W : default lane / input word width
//   STRIPE_CNT_W  : width of the emitted-pair counter
//   timer_w()     : width of a counter that must reach n
package stripe_pkg;
    typedef enum logic {EMPTY, HALF} state_t;
    localparam int STRIPE_DATA_W = 32;
    localparam int STRIPE_CNT_W  = 8;
    function automatic int timer_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/stripe_flush_timer.sv
// stripe_flush_timer: idle-cycle timer that releases a lone pending word
//   clk_2f   : clock, rising edge
//   reset_L  : asynchronous active-low reset
//   run      : a word is pending (striper in HALF)
//   valid_in : input word valid this cycle; restarts the count
//   expire   : this idle cycle is the FLUSH_CYC-th in a row; flush at the coming edge
module stripe_flush_timer
    import stripe_pkg::*;
#(
    parameter int FLUSH_CYC = 4
) (
    input  logic clk_2f,
    input  logic reset_L,
    input  logic run,
    input  logic valid_in,
    output logic expire
);
    localparam int TW = timer_w(FLUSH_CYC);
    localparam logic [TW-1:0] LAST = TW'(FLUSH_CYC - 1);

    logic [TW-1:0] timer;

    // The count reaches FLUSH_CYC on this idle edge, so the flush is registered
    // at the same edge and the counter restarts instead of holding FLUSH_CYC.
    assign expire = run && !valid_in && (timer == LAST);

    always_ff @(posedge clk_2f or negedge reset_L)
        if (!reset_L)
            timer <= '0;
        else
            timer <= (!run || valid_in || expire) ? '0 : timer + 1'b1;
endmodule

// File: rtl/byte_striping.sv
// byte_striping: splits a serial word stream into aligned even/odd lane pairs
//   clk_2f   : single clock, rising edge
//   reset_L  : asynchronous active-low reset
//   data_in  : serial word stream, DATA_W bits
//   valid_in : data_in valid this cycle
//   lane_0   : even-numbered word of the emitted pair (held between pulses)
//   lane_1   : odd-numbered word of the emitted pair (held between pulses)
//   valid_0  : one-cycle pulse, lane_0 carries a new word
//   valid_1  : one-cycle pulse, lane_1 carries a new word
//   pair_cnt : pairs emitted, flushes included, wraps at 256
// Optional feature: define BYTE_STRIPE_FLUSH_EN to flush a lone pending word
// to lane_0 after FLUSH_CYC idle cycles.
module byte_striping
    import stripe_pkg::*;
#(
    parameter int DATA_W    = STRIPE_DATA_W,
    parameter int FLUSH_CYC = 4
) (
    input  logic                    clk_2f,
    input  logic                    reset_L,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    valid_in,
    output logic [DATA_W-1:0]       lane_0,
    output logic [DATA_W-1:0]       lane_1,
    output logic                    valid_0,
    output logic                    valid_1,
    output logic [STRIPE_CNT_W-1:0] pair_cnt
);
    state_t            state;
    logic [DATA_W-1:0] hold_reg;
    logic              flush;

    if (FLUSH_CYC < 1) begin : g_bad_flush_cyc
        $error("byte_striping: FLUSH_CYC must be at least 1");
    end

`ifdef BYTE_STRIPE_FLUSH_EN
    stripe_flush_timer #(
        .FLUSH_CYC(FLUSH_CYC)
    ) u_flush_timer (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .run      (state == HALF),
        .valid_in (valid_in),
        .expire   (flush)
    );
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk_2f or negedge reset_L)
        if (!reset_L) begin
            state    <= EMPTY;
            hold_reg <= '0;
            lane_0   <= '0;
            lane_1   <= '0;
            valid_0  <= 1'b0;
            valid_1  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            if (state == EMPTY) begin
                if (valid_in) begin
                    hold_reg <= data_in;
                    state    <= HALF;
                end
            end else if (valid_in) begin
                // A real second word always beats a flush due in the same cycle.
                lane_0   <= hold_reg;
                lane_1   <= data_in;
                valid_0  <= 1'b1;
                valid_1  <= 1'b1;
                pair_cnt <= pair_cnt + 1'b1;
                state    <= EMPTY;
            end else if (flush) begin
                lane_0   <= hold_reg;
                lane_1   <= '0;
                valid_0  <= 1'b1;
                pair_cnt <= pair_cnt + 1'b1;
                state    <= EMPTY;
            end
        end
endmodule

// File: tb/tb_byte_striping.sv
// tb_byte_striping: scoreboard bench for byte_striping with a word-order reference model
module tb_byte_striping;
    localparam int FC = 4;

    logic        clk_2f = 1'b0;
    logic        reset_L = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [31:0] lane_0, lane_1;
    logic        valid_0, valid_1;
    logic [7:0]  pair_cnt;

    byte_striping #(.DATA_W(32), .FLUSH_CYC(FC)) dut (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .valid_in (valid_in),
        .lane_0   (lane_0),
        .lane_1   (lane_1),
        .valid_0  (valid_0),
        .valid_1  (valid_1),
        .pair_cnt (pair_cnt)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
        logic        v1;
        logic [7:0]  cnt;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned edges = 0;

    // reference model: word order only
    logic [31:0] pend = '0;
    bit          have = 0;
    int          idle = 0;
    int          npairs = 0;
    logic [31:0] last0 = '0, last1 = '0;

    always @(posedge clk_2f) edges <= edges + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input logic [31:0] l0, input logic [31:0] l1, input logic v1);
        exp_t e;
        npairs++;
        e.l0 = l0; e.l1 = l1; e.v1 = v1; e.cnt = 8'(npairs % 256); e.at = edges;
        sb.push_back(e);
        last0 = l0;
        last1 = l1;
        have = 0;
        idle = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_2f);
        #1;
        if (v) begin
            if (have) emit(pend, d, 1'b1);
            else begin
                pend = d;
                have = 1;
            end
            idle = 0;
        end else if (have) begin
`ifdef BYTE_STRIPE_FLUSH_EN
            idle++;
            if (idle == FC) emit(pend, 32'h0, 1'b0);
`endif
        end
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset_L  = 1'b0;
        #2;
        chk("reset_async", {lane_0, lane_1, valid_0, valid_1, pair_cnt}, '0);
        have = 0; idle = 0; npairs = 0; last0 = '0; last1 = '0;
        @(posedge clk_2f);
        #1;
        chk("reset_held", {lane_0, lane_1, valid_0, valid_1, pair_cnt}, '0);
        reset_L = 1'b1;
    endtask

    always @(negedge clk_2f) begin
        if (reset_L) begin
            if (valid_0 || valid_1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=v0:%b v1:%b l0:%h l1:%h required=no pulse at %0t",
                             valid_0, valid_1, lane_0, lane_1, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pair", {valid_0, valid_1, lane_0, lane_1, pair_cnt},
                        {1'b1, e.v1, e.l0, e.l1, e.cnt});
                    chk("latency", 80'(edges), 80'(e.at));
                end
            end else begin
                chk("hold", {lane_0, lane_1}, {last0, last1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // first pair after reset
        step(1, 32'hA000_0001);
        step(1, 32'hB000_0002);
        step(0, 0);
        chk("pair_cnt_1", pair_cnt, 8'd1);
        // eight back-to-back words
        for (int i = 1; i <= 8; i++) step(1, 32'(i));
        step(0, 0);
        chk("pair_cnt_5", pair_cnt, 8'd5);
        // idle gap inside a pair
        step(1, 32'h11);
        repeat (3) step(0, 0);
        step(1, 32'h22);
        repeat (2) step(0, 0);
        // reset while a word is pending
        step(1, 32'h44);
        do_reset();
        step(0, 0);
        step(1, 32'h55);
        step(1, 32'h66);
        repeat (2) step(0, 0);
        chk("pair_cnt_after_reset", pair_cnt, 8'd1);
        // randomized traffic with gaps
        for (int i = 0; i < 600; i++) step($urandom_range(0, 9) < 6, $urandom);
        repeat (FC + 2) step(0, 0);
        // counter wrap
        do_reset();
        for (int i = 0; i < 512; i++) step(1, $urandom);
        step(0, 0);
        chk("pair_cnt_wrap", pair_cnt, 8'd0);
        repeat (2) step(0, 0);
        chk("scoreboard_drained", 80'(sb.size()), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
